// File: rtl/tick_timer_bank.sv
// Timer bank: one shared prescaler produces a base tick; NCH channels count it down (one-shot or periodic).
// Optional build macro TICK_TIMER_PAUSE_EN adds a pause input that freezes prescaler, tick and counts.
module tick_timer_bank #(
  parameter int unsigned CLK_HZ  = 48_000_000,
  parameter int unsigned TICK_HZ = 1,
  parameter int unsigned NCH     = 2,
  parameter int unsigned CW      = 8
) (
  input  logic              clk,
  input  logic              reset,
`ifdef TICK_TIMER_PAUSE_EN
  input  logic              pause,
`endif
  input  logic [NCH-1:0]    start,
  input  logic [NCH-1:0]    stop,
  input  logic [NCH-1:0]    periodic,
  input  logic [NCH*CW-1:0] load_val,
  output logic              tick,
  output logic [NCH-1:0]    busy,
  output logic [NCH-1:0]    expire,
  output logic [NCH*CW-1:0] remaining
);

  localparam int unsigned DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned PW  = $clog2(DIV);

  typedef enum logic {IDLE, RUN} state_t;

  logic [PW-1:0] pcnt;
  logic          tick_q;
  logic          hold;
  logic          tick_en;

`ifdef TICK_TIMER_PAUSE_EN
  assign hold = pause;
`else
  assign hold = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcnt   <= '0;
      tick_q <= 1'b0;
    end else if (hold) begin
      tick_q <= 1'b0;
    end else if (pcnt == PW'(DIV - 1)) begin
      pcnt   <= '0;
      tick_q <= 1'b1;
    end else begin
      pcnt   <= pcnt + 1'b1;
      tick_q <= 1'b0;
    end
  end

  // A tick already registered when pause rises must not reach the channels.
  assign tick    = tick_q;
  assign tick_en = tick_q & ~hold;

  state_t        state_q [NCH];
  state_t        state_d [NCH];
  logic [CW-1:0] rem_q   [NCH];
  logic [CW-1:0] rem_d   [NCH];
  logic [CW-1:0] rld_q   [NCH];
  logic [CW-1:0] rld_d   [NCH];
  logic [NCH-1:0] mode_q, mode_d;
  logic [NCH-1:0] exp_q, exp_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        state_q[i] <= IDLE;
        rem_q[i]   <= '0;
        rld_q[i]   <= '0;
      end
      mode_q <= '0;
      exp_q  <= '0;
    end else begin
      for (int unsigned i = 0; i < NCH; i++) begin
        state_q[i] <= state_d[i];
        rem_q[i]   <= rem_d[i];
        rld_q[i]   <= rld_d[i];
      end
      mode_q <= mode_d;
      exp_q  <= exp_d;
    end
  end

  // Per-edge priority: stop, then start, then tick.
  always_comb begin
    mode_d = mode_q;
    exp_d  = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      state_d[i] = state_q[i];
      rem_d[i]   = rem_q[i];
      rld_d[i]   = rld_q[i];
      if (stop[i]) begin
        state_d[i] = IDLE;
        rem_d[i]   = '0;
      end else if (start[i]) begin
        if (load_val[i*CW +: CW] == '0) begin
          exp_d[i]   = 1'b1;
          rem_d[i]   = '0;
          state_d[i] = IDLE;
        end else begin
          rem_d[i]   = load_val[i*CW +: CW];
          rld_d[i]   = load_val[i*CW +: CW];
          mode_d[i]  = periodic[i];
          state_d[i] = RUN;
        end
      end else if (state_q[i] == RUN && tick_en) begin
        if (rem_q[i] <= CW'(1)) begin
          exp_d[i] = 1'b1;
          if (mode_q[i]) begin
            rem_d[i] = rld_q[i];
          end else begin
            rem_d[i]   = '0;
            state_d[i] = IDLE;
          end
        end else begin
          rem_d[i] = rem_q[i] - 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_out
    assign remaining[g*CW +: CW] = rem_q[g];
    assign busy[g]               = (state_q[g] == RUN);
  end
  assign expire = exp_q;

endmodule

// File: tb/tb_tick_timer_bank.sv
// Scoreboard bench for tick_timer_bank: a cycle model queues expected outputs, a monitor compares at negedge.
module tb_tick_timer_bank;
  localparam int unsigned NCH = 2;
  localparam int unsigned CW  = 8;
  localparam int unsigned DIV = 10;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              pause_v = 1'b0;
  logic [NCH-1:0]    start = '0, stop = '0, periodic = '0;
  logic [NCH*CW-1:0] load_val = '0;
  logic              tick;
  logic [NCH-1:0]    busy, expire;
  logic [NCH*CW-1:0] remaining;

  tick_timer_bank #(.CLK_HZ(10), .TICK_HZ(1), .NCH(NCH), .CW(CW)) dut (
    .clk(clk),
    .reset(reset),
`ifdef TICK_TIMER_PAUSE_EN
    .pause(pause_v),
`endif
    .start(start),
    .stop(stop),
    .periodic(periodic),
    .load_val(load_val),
    .tick(tick),
    .busy(busy),
    .expire(expire),
    .remaining(remaining)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic              tick;
    logic [NCH-1:0]    busy;
    logic [NCH-1:0]    expire;
    logic [NCH*CW-1:0] rem;
  } obs_t;

  obs_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: edges since reset release, plus per-channel count/reload/mode/running.
  int unsigned n_edges;
  bit          m_tick;
  int          m_rem [NCH];
  int          m_rld [NCH];
  bit          m_per [NCH];
  bit          m_run [NCH];
  bit          m_exp [NCH];

  function automatic obs_t model_obs();
    obs_t o;
    o.tick = m_tick;
    for (int i = 0; i < NCH; i++) begin
      o.busy[i]            = m_run[i];
      o.expire[i]          = m_exp[i];
      o.rem[i*CW +: CW]    = CW'(m_rem[i]);
    end
    return o;
  endfunction

  function automatic void model_reset();
    n_edges = 0;
    m_tick  = 0;
    for (int i = 0; i < NCH; i++) begin
      m_rem[i] = 0; m_rld[i] = 0; m_per[i] = 0; m_run[i] = 0; m_exp[i] = 0;
    end
  endfunction

  function automatic void model_edge();
    bit t;
    int lv;
    if (!reset) begin
      model_reset();
      return;
    end
    t = m_tick && !pause_v;
    for (int i = 0; i < NCH; i++) begin
      lv = int'(load_val[i*CW +: CW]);
      m_exp[i] = 0;
      if (stop[i]) begin
        m_run[i] = 0; m_rem[i] = 0;
      end else if (start[i]) begin
        if (lv == 0) begin
          m_exp[i] = 1; m_rem[i] = 0; m_run[i] = 0;
        end else begin
          m_rem[i] = lv; m_rld[i] = lv; m_per[i] = periodic[i]; m_run[i] = 1;
        end
      end else if (m_run[i] && t) begin
        m_rem[i] = m_rem[i] - 1;
        if (m_rem[i] == 0) begin
          m_exp[i] = 1;
          if (m_per[i]) m_rem[i] = m_rld[i];
          else m_run[i] = 0;
        end
      end
    end
    if (pause_v) begin
      m_tick = 0;
    end else begin
      n_edges++;
      m_tick = (n_edges % DIV) == 0;
    end
  endfunction

  function automatic void check(string name, obs_t got, obs_t exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got tick=%0b busy=%b expire=%b remaining=%h, expected tick=%0b busy=%b expire=%b remaining=%h",
               name, got.tick, got.busy, got.expire, got.rem, exp.tick, exp.busy, exp.expire, exp.rem);
    end
  endfunction

  function automatic obs_t dut_obs();
    obs_t o;
    o.tick = tick; o.busy = busy; o.expire = expire; o.rem = remaining;
    return o;
  endfunction

  initial begin : monitor
    obs_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("cycle", dut_obs(), e);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    model_edge();
    q.push_back(model_obs());
    #1;
  endtask

  task automatic drive(int ch, bit st, bit sp, bit per, int lv);
    start[ch] = st; stop[ch] = sp; periodic[ch] = per;
    load_val[ch*CW +: CW] = CW'(lv);
    step();
    start = '0; stop = '0;
  endtask

  task automatic idle(int k);
    for (int i = 0; i < k; i++) step();
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    obs_t zero;
    int guard;
    zero = '0;
    model_reset();
    #1 check("reset_async", dut_obs(), zero);
    idle(5);
    reset = 1'b1;
    idle(35);

    drive(0, 1, 0, 0, 3);
    idle(40);

    drive(1, 1, 0, 1, 2);
    idle(105);
    drive(1, 0, 1, 0, 0);
    idle(3);

    drive(0, 1, 0, 1, 0);
    idle(3);
    start[1] = 1; stop[1] = 1; load_val[CW +: CW] = 8'd5;
    step();
    start = '0; stop = '0;
    idle(3);

    drive(0, 1, 0, 0, 2);
    guard = 0;
    while (m_rem[0] != 1 && guard < 40) begin step(); guard++; end
    if (m_rem[0] != 1) begin
      vectors++; miscompares++;
      $display("FAIL restart_wait: remaining never reached 1 (got %0d, expected 1)", m_rem[0]);
    end
    drive(0, 1, 0, 0, 4);
    idle(50);

    drive(1, 1, 0, 1, 3);
    idle(7);
    @(negedge clk);
    #1 reset = 1'b0;
    #1 check("reset_midrun", dut_obs(), zero);
    idle(3);
    reset = 1'b1;
    idle(12);

`ifdef TICK_TIMER_PAUSE_EN
    drive(0, 1, 0, 0, 5);
    idle(13);
    pause_v = 1'b1;
    idle(25);
    pause_v = 1'b0;
    idle(40);
`endif

    for (int c = 0; c < 3000; c++) begin
      for (int ch = 0; ch < NCH; ch++) begin
        start[ch]    = ($urandom_range(0, 19) == 0);
        stop[ch]     = ($urandom_range(0, 59) == 0);
        periodic[ch] = $urandom_range(0, 1);
        load_val[ch*CW +: CW] = ($urandom_range(0, 9) == 0) ? CW'($urandom_range(0, 255))
                                                             : CW'($urandom_range(0, 6));
      end
`ifdef TICK_TIMER_PAUSE_EN
      if ($urandom_range(0, 39) == 0) pause_v = ~pause_v;
`endif
      step();
    end
    start = '0; stop = '0; pause_v = 1'b0;
    idle(5);

    @(negedge clk);
    @(negedge clk);
    if (q.size() != 0) begin
      vectors++; miscompares++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
